fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the decoder.
- Owns the program counter and issues word reads to the synchronous instruction memory (1-cycle read latency).
- Buffers returned words in a small FIFO and presents them to the decoder over a valid/ready handshake.
- Accepts PC redirects from downstream (taken branch/jump) and squashes stale fetches.

---
 rtl/riscv_pkg.sv | 13 +
 rtl/fetch_unit_if.sv | 28 ++
 rtl/fetch_fifo.sv | 57 +++++
 rtl/fetch_unit.sv | 84 ++++++++
 tb/tb_fetch_unit.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-path types and defaults for the RISC-V front end.
package riscv_pkg;

   localparam int unsigned BYTE_ADDR_W = 12;
   localparam int unsigned WORD_ADDR_W = BYTE_ADDR_W - 2;
   localparam logic [31:0] RISCV_NOP   = 32'h0000_0013;

   typedef struct packed {
      logic [31:0]            inst;
      logic [BYTE_ADDR_W-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory read port, decoder handshake, redirect and error.
interface fetch_unit_if #(
   parameter int unsigned BYTE_ADDR_W = riscv_pkg::BYTE_ADDR_W
);
   localparam int unsigned WORD_ADDR_W = BYTE_ADDR_W - 2;

   logic                   mem_rd_en_o;
   logic [WORD_ADDR_W-1:0] mem_addr_o;
   logic [31:0]            mem_data_i;
   logic                   inst_valid_o;
   logic [31:0]            inst_o;
   logic [BYTE_ADDR_W-1:0] inst_pc_o;
   logic                   dec_ready_i;
   logic                   redirect_i;
   logic [BYTE_ADDR_W-1:0] redirect_pc_i;
   logic                   fetch_err_o;

   modport master (
      output mem_rd_en_o, mem_addr_o, inst_valid_o, inst_o, inst_pc_o, fetch_err_o,
      input  mem_data_i, dec_ready_i, redirect_i, redirect_pc_i
   );

   modport slave (
      input  mem_rd_en_o, mem_addr_o, inst_valid_o, inst_o, inst_pc_o, fetch_err_o,
      output mem_data_i, dec_ready_i, redirect_i, redirect_pc_i
   );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {inst, pc} entries with single-cycle flush.
module fetch_fifo
   import riscv_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                       clk_i,
   input  logic                       rstn_i,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic                       i_flush,
   input  fetch_entry_t               i_entry,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_full,
   output logic                       o_empty,
   output fetch_entry_t               o_head
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   fetch_entry_t     r_mem [DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [CNT_W-1:0] r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign w_do_pop  = i_pop && (r_count != '0);
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_mem   <= '{default: '0};
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wptr] <= i_entry;
            r_wptr        <= r_wptr + PTR_W'(1);
         end
         if (w_do_pop) r_rptr <= r_rptr + PTR_W'(1);
         r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
      end
   end

   assign o_count = r_count;
   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_head  = r_mem[r_rptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads a 1-cycle-latency memory and buffers words for decode.
module fetch_unit #(
   parameter int unsigned             BYTE_ADDR_W = riscv_pkg::BYTE_ADDR_W,
   parameter logic [BYTE_ADDR_W-1:0]  RESET_PC    = '0,
   parameter int unsigned             BUF_DEPTH   = 2
) (
   input  logic           clk_i,
   input  logic           rstn_i,
   fetch_unit_if.master   fetch
);
   import riscv_pkg::fetch_entry_t;

   localparam int unsigned CNT_W      = $clog2(BUF_DEPTH) + 1;
   localparam int unsigned OCC_W      = CNT_W + 1;
   localparam int unsigned ENTRY_PC_W = riscv_pkg::BYTE_ADDR_W;

   logic [BYTE_ADDR_W-1:0] r_pc;
   logic [BYTE_ADDR_W-1:0] r_issue_pc;
   logic                   r_inflight;
   logic                   r_err;

   logic [CNT_W-1:0]       w_count;
   logic [OCC_W-1:0]       w_occ;
   logic                   w_full;
   logic                   w_empty;
   logic                   w_pop;
   logic                   w_push;
   logic                   w_issue;
   fetch_entry_t           w_head;
   fetch_entry_t           w_entry;

   // Redirect wins over everything: it flushes, drops the returning word and blocks issue.
   always_comb begin
      w_pop   = !w_empty && fetch.dec_ready_i && !fetch.redirect_i;
      w_push  = r_inflight && !fetch.redirect_i;
      w_occ   = {1'b0, w_count} + OCC_W'(r_inflight) - OCC_W'(w_pop);
      w_issue = rstn_i && !r_err && !fetch.redirect_i && (w_occ < OCC_W'(BUF_DEPTH));
      w_entry = '{inst: fetch.mem_data_i, pc: ENTRY_PC_W'(r_issue_pc)};
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_pc       <= RESET_PC;
         r_issue_pc <= '0;
         r_inflight <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_inflight <= w_issue;
         if (fetch.redirect_i) begin
            r_pc <= fetch.redirect_pc_i;
            if (fetch.redirect_pc_i[1:0] != 2'b00) r_err <= 1'b1;
         end else if (w_issue) begin
            r_pc       <= r_pc + BYTE_ADDR_W'(4);
            r_issue_pc <= r_pc;
         end
      end
   end

   fetch_fifo #(
      .DEPTH (BUF_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (fetch.redirect_i),
      .i_entry (w_entry),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_head  (w_head)
   );

   a_no_overflow : assert property (@(posedge clk_i) disable iff (!rstn_i)
      !(w_push && w_full && !w_pop));

   assign fetch.mem_rd_en_o  = w_issue;
   assign fetch.mem_addr_o   = rstn_i ? r_pc[BYTE_ADDR_W-1:2] : '0;
   assign fetch.inst_valid_o = !w_empty;
   assign fetch.inst_o       = w_head.inst;
   assign fetch.inst_pc_o    = BYTE_ADDR_W'(w_head.pc);
   assign fetch.fetch_err_o  = r_err;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected {inst, pc} stream queued on reset/redirect, checked on each pop.
module tb_fetch_unit;
   import riscv_pkg::*;

   localparam int unsigned AW    = 12;
   localparam int unsigned WAW   = AW - 2;
   localparam int unsigned DEPTH = 2;

   logic clk_i  = 1'b0;
   logic rstn_i = 1'b1;

   fetch_unit_if #(.BYTE_ADDR_W(AW)) bus ();

   fetch_unit #(
      .BYTE_ADDR_W (AW),
      .RESET_PC    (12'h000),
      .BUF_DEPTH   (DEPTH)
   ) dut (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .fetch  (bus.master)
   );

   always #5 clk_i = ~clk_i;

   logic [31:0]  mem [1024];
   fetch_entry_t sb_q [$];
   int           n_cmp   = 0;
   int           n_err   = 0;
   int           n_deliv = 0;

   // Synchronous instruction memory, one cycle of read latency.
   always @(posedge clk_i) begin
      if (bus.mem_rd_en_o) bus.mem_data_i <= mem[bus.mem_addr_o];
      else                 bus.mem_data_i <= 32'hDEAD_BEEF;
   end

   task automatic cyc(input logic rdy, input logic redir, input logic [AW-1:0] rpc);
      @(negedge clk_i);
      bus.dec_ready_i   = rdy;
      bus.redirect_i    = redir;
      bus.redirect_pc_i = rpc;
      #1;
   endtask

   task automatic sb_fill(input logic [AW-1:0] start);
      logic [AW-1:0] pc;
      fetch_entry_t  e;
      pc = start;
      sb_q.delete();
      for (int i = 0; i < 64; i++) begin
         e.inst = mem[pc[AW-1:2]];
         e.pc   = pc;
         sb_q.push_back(e);
         pc = pc + 12'd4;
      end
   endtask

   task automatic do_release(input logic rdy);
      @(negedge clk_i);
      rstn_i            = 1'b1;
      bus.dec_ready_i   = rdy;
      bus.redirect_i    = 1'b0;
      bus.redirect_pc_i = '0;
      sb_fill(12'h000);
      #1;
   endtask

   task automatic test_reset();
      fetch_entry_t e;
      bus.dec_ready_i   = 1'b0;
      bus.redirect_i    = 1'b0;
      bus.redirect_pc_i = '0;
      rstn_i            = 1'b0;
      repeat (3) @(negedge clk_i);
      #1;
      n_cmp++; if (bus.mem_rd_en_o !== 1'b0) begin n_err++; $display("FAIL reset_rd_en: got %b, required 0", bus.mem_rd_en_o); end
      n_cmp++; if (bus.mem_addr_o !== 10'h000) begin n_err++; $display("FAIL reset_addr: got %h, required 000", bus.mem_addr_o); end
      n_cmp++; if (bus.inst_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b, required 0", bus.inst_valid_o); end
      n_cmp++; if (bus.inst_o !== 32'h0) begin n_err++; $display("FAIL reset_inst: got %h, required 0", bus.inst_o); end
      n_cmp++; if (bus.inst_pc_o !== 12'h000) begin n_err++; $display("FAIL reset_pc: got %h, required 000", bus.inst_pc_o); end
      n_cmp++; if (bus.fetch_err_o !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b, required 0", bus.fetch_err_o); end
      do_release(1'b1);
      for (int c = 0; c < 4; c++) begin
         if (c > 0) cyc(1'b1, 1'b0, '0);
         n_cmp++; if (bus.mem_rd_en_o !== 1'b1 || bus.mem_addr_o !== WAW'(c)) begin
            n_err++; $display("FAIL first_reads c%0d: got en %b addr %h, required en 1 addr %h", c, bus.mem_rd_en_o, bus.mem_addr_o, c);
         end
         if (c < 2) begin
            n_cmp++; if (bus.inst_valid_o !== 1'b0) begin n_err++; $display("FAIL first_latency c%0d: got valid %b, required 0", c, bus.inst_valid_o); end
         end
         if (c == 2) begin
            n_cmp++; if (bus.inst_valid_o !== 1'b1 || bus.inst_o !== 32'h0050_0093 || bus.inst_pc_o !== 12'h000) begin
               n_err++; $display("FAIL first_inst: got v%b %h @%h, required v1 00500093 @000", bus.inst_valid_o, bus.inst_o, bus.inst_pc_o);
            end
         end
         if (c == 3) begin
            n_cmp++; if (bus.inst_valid_o !== 1'b1 || bus.inst_o !== 32'h00A0_0113 || bus.inst_pc_o !== 12'h004) begin
               n_err++; $display("FAIL second_inst: got v%b %h @%h, required v1 00a00113 @004", bus.inst_valid_o, bus.inst_o, bus.inst_pc_o);
            end
         end
         if (bus.inst_valid_o && bus.dec_ready_i) begin
            n_cmp++;
            if (sb_q.size() == 0) begin n_err++; $display("FAIL deliver_extra: got pc %h, required no delivery", bus.inst_pc_o); end
            else begin
               e = sb_q.pop_front(); n_deliv++;
               if (bus.inst_pc_o !== e.pc || bus.inst_o !== e.inst) begin n_err++; $display("FAIL deliver: got pc %h inst %h, required pc %h inst %h", bus.inst_pc_o, bus.inst_o, e.pc, e.inst); end
            end
         end
      end
   endtask

   task automatic test_stall();
      fetch_entry_t e;
      int n_iss;
      int d0;
      n_iss = 0;
      @(negedge clk_i);
      rstn_i = 1'b0;
      repeat (2) @(negedge clk_i);
      do_release(1'b0);
      for (int c = 0; c < 5; c++) begin
         if (c > 0) cyc(1'b0, 1'b0, '0);
         if (bus.mem_rd_en_o === 1'b1) n_iss++;
         if (c >= 2) begin
            n_cmp++; if (bus.inst_valid_o !== 1'b1 || bus.inst_o !== 32'h0050_0093 || bus.inst_pc_o !== 12'h000) begin
               n_err++; $display("FAIL stall_hold c%0d: got v%b %h @%h, required v1 00500093 @000", c, bus.inst_valid_o, bus.inst_o, bus.inst_pc_o);
            end
         end
      end
      n_cmp++; if (n_iss != DEPTH) begin n_err++; $display("FAIL stall_reads: got %0d, required %0d", n_iss, DEPTH); end
      n_cmp++; if (bus.mem_rd_en_o !== 1'b0) begin n_err++; $display("FAIL stall_rd_en: got %b, required 0", bus.mem_rd_en_o); end
      d0 = n_deliv;
      for (int c = 0; c < 10; c++) begin
         cyc(1'b1, 1'b0, '0);
         if (bus.inst_valid_o && bus.dec_ready_i) begin
            n_cmp++;
            if (sb_q.size() == 0) begin n_err++; $display("FAIL deliver_extra: got pc %h, required no delivery", bus.inst_pc_o); end
            else begin
               e = sb_q.pop_front(); n_deliv++;
               if (bus.inst_pc_o !== e.pc || bus.inst_o !== e.inst) begin n_err++; $display("FAIL deliver: got pc %h inst %h, required pc %h inst %h", bus.inst_pc_o, bus.inst_o, e.pc, e.inst); end
            end
         end
      end
      n_cmp++; if (n_deliv - d0 != 10) begin n_err++; $display("FAIL stall_resume_count: got %0d, required 10", n_deliv - d0); end
   endtask

   task automatic test_redirect();
      fetch_entry_t e;
      int d0;
      cyc(1'b1, 1'b1, 12'h100);
      n_cmp++; if (bus.inst_valid_o !== 1'b1 || bus.mem_rd_en_o !== 1'b0) begin
         n_err++; $display("FAIL redir_cycle: got valid %b en %b, required valid 1 en 0", bus.inst_valid_o, bus.mem_rd_en_o);
      end
      sb_fill(12'h100);
      cyc(1'b1, 1'b0, '0);
      n_cmp++; if (bus.inst_valid_o !== 1'b0) begin n_err++; $display("FAIL redir_flush: got valid %b, required 0", bus.inst_valid_o); end
      n_cmp++; if (bus.mem_rd_en_o !== 1'b1 || bus.mem_addr_o !== 10'h040) begin
         n_err++; $display("FAIL redir_addr: got en %b addr %h, required en 1 addr 040", bus.mem_rd_en_o, bus.mem_addr_o);
      end
      cyc(1'b1, 1'b0, '0);
      n_cmp++; if (bus.inst_valid_o !== 1'b0) begin n_err++; $display("FAIL redir_squash: got valid %b, required 0", bus.inst_valid_o); end
      d0 = n_deliv;
      for (int c = 0; c < 8; c++) begin
         cyc(1'b1, 1'b0, '0);
         if (c == 0) begin
            n_cmp++; if (bus.inst_pc_o !== 12'h100) begin n_err++; $display("FAIL redir_first_pc: got %h, required 100", bus.inst_pc_o); end
         end
         if (bus.inst_valid_o && bus.dec_ready_i) begin
            n_cmp++;
            if (sb_q.size() == 0) begin n_err++; $display("FAIL deliver_extra: got pc %h, required no delivery", bus.inst_pc_o); end
            else begin
               e = sb_q.pop_front(); n_deliv++;
               if (bus.inst_pc_o !== e.pc || bus.inst_o !== e.inst) begin n_err++; $display("FAIL deliver: got pc %h inst %h, required pc %h inst %h", bus.inst_pc_o, bus.inst_o, e.pc, e.inst); end
            end
         end
      end
      n_cmp++; if (n_deliv - d0 != 8) begin n_err++; $display("FAIL redir_count: got %0d, required 8", n_deliv - d0); end
   endtask

   task automatic test_back_to_back();
      fetch_entry_t e;
      int d0;
      cyc(1'b1, 1'b1, 12'h200);
      n_cmp++; if (bus.mem_rd_en_o !== 1'b0) begin n_err++; $display("FAIL b2b_first_en: got %b, required 0", bus.mem_rd_en_o); end
      cyc(1'b1, 1'b1, 12'h300);
      n_cmp++; if (bus.mem_rd_en_o !== 1'b0 || bus.inst_valid_o !== 1'b0) begin
         n_err++; $display("FAIL b2b_second: got en %b valid %b, required en 0 valid 0", bus.mem_rd_en_o, bus.inst_valid_o);
      end
      sb_fill(12'h300);
      d0 = n_deliv;
      for (int c = 0; c < 7; c++) begin
         cyc(1'b1, 1'b0, '0);
         if (c == 0) begin
            n_cmp++; if (bus.mem_addr_o !== 10'h0C0) begin n_err++; $display("FAIL b2b_addr: got %h, required 0c0", bus.mem_addr_o); end
         end
         if (bus.inst_valid_o && bus.dec_ready_i) begin
            n_cmp++;
            if (sb_q.size() == 0) begin n_err++; $display("FAIL deliver_extra: got pc %h, required no delivery", bus.inst_pc_o); end
            else begin
               e = sb_q.pop_front(); n_deliv++;
               if (bus.inst_pc_o !== e.pc || bus.inst_o !== e.inst) begin n_err++; $display("FAIL deliver: got pc %h inst %h, required pc %h inst %h", bus.inst_pc_o, bus.inst_o, e.pc, e.inst); end
            end
         end
      end
      n_cmp++; if (n_deliv - d0 != 5) begin n_err++; $display("FAIL b2b_count: got %0d, required 5", n_deliv - d0); end
   endtask

   task automatic test_wrap();
      fetch_entry_t   e;
      logic [WAW-1:0] exp_addr;
      int d0;
      cyc(1'b1, 1'b1, 12'hFF8);
      sb_fill(12'hFF8);
      exp_addr = 10'h3FE;
      d0 = n_deliv;
      for (int c = 0; c < 8; c++) begin
         cyc(1'b1, 1'b0, '0);
         if (bus.mem_rd_en_o === 1'b1) begin
            n_cmp++; if (bus.mem_addr_o !== exp_addr) begin n_err++; $display("FAIL wrap_addr: got %h, required %h", bus.mem_addr_o, exp_addr); end
            exp_addr = exp_addr + 10'd1;
         end
         if (bus.inst_valid_o && bus.dec_ready_i) begin
            n_cmp++;
            if (sb_q.size() == 0) begin n_err++; $display("FAIL deliver_extra: got pc %h, required no delivery", bus.inst_pc_o); end
            else begin
               e = sb_q.pop_front(); n_deliv++;
               if (bus.inst_pc_o !== e.pc || bus.inst_o !== e.inst) begin n_err++; $display("FAIL deliver: got pc %h inst %h, required pc %h inst %h", bus.inst_pc_o, bus.inst_o, e.pc, e.inst); end
            end
         end
      end
      n_cmp++; if (n_deliv - d0 != 6) begin n_err++; $display("FAIL wrap_count: got %0d, required 6", n_deliv - d0); end
   endtask

   task automatic test_misaligned();
      cyc(1'b1, 1'b1, 12'h102);
      n_cmp++; if (bus.mem_rd_en_o !== 1'b0 || bus.fetch_err_o !== 1'b0) begin
         n_err++; $display("FAIL misal_cycle: got en %b err %b, required en 0 err 0", bus.mem_rd_en_o, bus.fetch_err_o);
      end
      for (int c = 0; c < 6; c++) begin
         cyc(1'(c % 2), (c == 3), 12'h200);
         n_cmp++; if (bus.fetch_err_o !== 1'b1 || bus.mem_rd_en_o !== 1'b0 || bus.inst_valid_o !== 1'b0) begin
            n_err++; $display("FAIL misal_hold c%0d: got err %b en %b valid %b, required err 1 en 0 valid 0", c, bus.fetch_err_o, bus.mem_rd_en_o, bus.inst_valid_o);
         end
      end
   endtask

   task automatic test_reset_mid();
      fetch_entry_t e;
      int d0;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk_i);
         #2;
         rstn_i = 1'b0;
         #1;
         n_cmp++; if ({bus.mem_rd_en_o, bus.inst_valid_o, bus.fetch_err_o} !== 3'b000 || bus.inst_o !== 32'h0) begin
            n_err++; $display("FAIL mid_reset k%0d: got en %b valid %b err %b inst %h, required all 0", k, bus.mem_rd_en_o, bus.inst_valid_o, bus.fetch_err_o, bus.inst_o);
         end
         do_release(1'b1);
         n_cmp++; if (bus.mem_rd_en_o !== 1'b1 || bus.mem_addr_o !== 10'h000) begin
            n_err++; $display("FAIL mid_release k%0d: got en %b addr %h, required en 1 addr 000", k, bus.mem_rd_en_o, bus.mem_addr_o);
         end
         d0 = n_deliv;
         for (int c = 0; c < 6; c++) begin
            cyc(1'b1, 1'b0, '0);
            if (bus.inst_valid_o && bus.dec_ready_i) begin
               n_cmp++;
               if (sb_q.size() == 0) begin n_err++; $display("FAIL deliver_extra: got pc %h, required no delivery", bus.inst_pc_o); end
               else begin
                  e = sb_q.pop_front(); n_deliv++;
                  if (bus.inst_pc_o !== e.pc || bus.inst_o !== e.inst) begin n_err++; $display("FAIL deliver: got pc %h inst %h, required pc %h inst %h", bus.inst_pc_o, bus.inst_o, e.pc, e.inst); end
               end
            end
         end
         n_cmp++; if (n_deliv - d0 != 5) begin n_err++; $display("FAIL mid_count k%0d: got %0d, required 5", k, n_deliv - d0); end
      end
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: time %0t, required finish before 50000", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
      mem[0] = 32'h0050_0093;
      mem[1] = 32'h00A0_0113;
      test_reset();
      test_stall();
      test_redirect();
      test_back_to_back();
      test_wrap();
      test_misaligned();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
